microc: RTL and testbench

MICROC -- requirements
Module: microc

---
 rtl/microc_pkg.sv | 44 ++++
 rtl/microc_regfile.sv | 27 ++
 rtl/microc.sv | 48 ++++
 tb/tb_microc.sv | 133 +++++++++++++
 4 files changed

// File: rtl/microc_pkg.sv
// microc_pkg: shared widths, instruction field positions and ALU op codes for microc and its control unit.
package microc_pkg;
    localparam int PC_W    = 10;
    localparam int DATA_W  = 8;
    localparam int RA_W    = 4;
    localparam int OP_W    = 6;
    localparam int INSTR_W = 16;
    localparam int NREG    = 16;
    localparam int MEM_D   = 1 << PC_W;

    localparam int OPC_LSB  = 10;
    localparam int SRCA_LSB = 8;
    localparam int SRCB_LSB = 4;
    localparam int DST_LSB  = 0;
    localparam int IMM_LSB  = 4;
    localparam int JMP_LSB  = 0;

    typedef enum logic [2:0] {
        ALU_A    = 3'b000,
        ALU_NOTA = 3'b001,
        ALU_ADD  = 3'b010,
        ALU_SUB  = 3'b011,
        ALU_AND  = 3'b100,
        ALU_OR   = 3'b101,
        ALU_NEGA = 3'b110,
        ALU_NEGB = 3'b111
    } alu_op_e;

    // Every result is truncated to DATA_W, so carries and borrows vanish.
    function automatic logic [DATA_W-1:0] alu_eval(alu_op_e op, logic [DATA_W-1:0] a, logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] r;
        unique case (op)
            ALU_A:    r = a;
            ALU_NOTA: r = ~a;
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_NEGA: r = -a;
            default:  r = -b;
        endcase
        return r;
    endfunction
endpackage

// File: rtl/microc_regfile.sv
// regfile: 16x8 register file, two combinational read ports, one write port; R0 is hardwired to zero.
module regfile
    import microc_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [RA_W-1:0]   ra_a,
    input  logic [RA_W-1:0]   ra_b,
    input  logic [RA_W-1:0]   wa,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd_a,
    output logic [DATA_W-1:0] rd_b
);
    logic [DATA_W-1:0] regs [NREG];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (we && wa != '0) begin
            regs[wa] <= wd;
        end
    end

    assign rd_a = (ra_a == '0) ? '0 : regs[ra_a];
    assign rd_b = (ra_b == '0) ? '0 : regs[ra_b];
endmodule

// File: rtl/microc.sv
// microc: single-cycle 8-bit datapath (PC, program ROM, register file, ALU, zero flag) driven by an external control unit.
module microc
    import microc_pkg::*;
#(
    parameter string PROGFILE = "progfile.dat"
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_inc,
    input  logic            s_inm,
    input  logic            we,
    input  logic            wez,
    input  logic [2:0]      AluOP,
    output logic [OP_W-1:0] Opcode,
    output logic            zero
);
    logic [INSTR_W-1:0] mem [MEM_D];
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic [DATA_W-1:0]  rd_a, rd_b, alu_y, wd;

    assign instr  = mem[pc];
    assign Opcode = instr[OPC_LSB +: OP_W];
    assign alu_y  = alu_eval(alu_op_e'(AluOP), rd_a, rd_b);
    assign wd     = s_inm ? instr[IMM_LSB +: DATA_W] : alu_y;

    regfile u_rf (
        .clk  (clk),
        .reset(reset),
        .we   (we),
        .ra_a (instr[SRCA_LSB +: RA_W]),
        .ra_b (instr[SRCB_LSB +: RA_W]),
        .wa   (instr[DST_LSB +: RA_W]),
        .wd   (wd),
        .rd_a (rd_a),
        .rd_b (rd_b)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc   <= '0;
            zero <= 1'b0;
        end else begin
            pc   <= s_inc ? pc + 1'b1 : instr[JMP_LSB +: PC_W];
            zero <= wez ? (alu_y == '0) : zero;
        end
    end
endmodule

// File: tb/tb_microc.sv
// tb_microc: table-driven scoreboard bench for microc; program is loaded directly into the ROM array.
module tb_microc;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       s_inc = 1'b1, s_inm = 1'b0, we = 1'b0, wez = 1'b0;
    logic [2:0] AluOP = 3'b000;
    logic [5:0] Opcode;
    logic       zero;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       s_inc, s_inm, we, wez;
        logic [2:0] op;
        int         ridx;
        logic [7:0] rval;
        logic       zero;
        logic [5:0] opc;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    microc #(.PROGFILE("")) dut (
        .clk   (clk),
        .reset (reset),
        .s_inc (s_inc),
        .s_inm (s_inm),
        .we    (we),
        .wez   (wez),
        .AluOP (AluOP),
        .Opcode(Opcode),
        .zero  (zero)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic inc, logic inm, logic w, logic wz, logic [2:0] op,
                                int ridx, logic [7:0] rval, logic z, logic [5:0] opc);
        vec_t v;
        v.s_inc = inc; v.s_inm = inm; v.we = w; v.wez = wz; v.op = op;
        v.ridx = ridx; v.rval = rval; v.zero = z; v.opc = opc;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step(vec_t v, string tag);
        vec_t e;
        s_inc = v.s_inc; s_inm = v.s_inm; we = v.we; wez = v.wez; AluOP = v.op;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({tag, " zero"}, 32'(zero), 32'(e.zero));
        chk({tag, " opcode"}, 32'(Opcode), 32'(e.opc));
        chk($sformatf("%s R%0d", tag, e.ridx), 32'(dut.u_rf.regs[e.ridx]), 32'(e.rval));
    endtask

    initial begin
        logic [7:0] alu_exp [8];
        alu_exp = '{8'd200, 8'd55, 8'd44, 8'd100, 8'd64, 8'd236, 8'd56, 8'd156};
        for (int i = 0; i < 1024; i++) dut.mem[i] = 16'h0000;
        dut.mem[0]    = 16'b1000_0000_1111_0001;
        dut.mem[1]    = 16'b1000_0000_0001_0010;
        dut.mem[2]    = 16'b0010_0001_0010_0011;
        dut.mem[3]    = 16'b1100_0000_0000_1111;
        dut.mem[15]   = 16'b1000_0000_0001_0100;
        dut.mem[16]   = 16'b0011_0001_0001_0101;
        dut.mem[17]   = 16'b0010_0001_0010_0110;
        dut.mem[18]   = 16'b1000_1111_1111_0000;
        dut.mem[19]   = 16'b0010_0000_0000_1011;
        dut.mem[20]   = 16'b1000_1100_1000_0111;
        dut.mem[21]   = 16'b1000_0110_0100_1000;
        dut.mem[22]   = 16'b0010_0111_1000_1001;
        for (int i = 23; i <= 30; i++) dut.mem[i] = 16'b0000_0111_1000_1010;
        dut.mem[31]   = 16'b1000_0101_0000_1100;
        dut.mem[32]   = 16'b1100_0011_1111_1111;
        dut.mem[1023] = 16'b1111_1100_0000_0000;

        vecs.push_back(mk(1, 1, 1, 0, 3'd0, 1, 8'd15, 0, 6'b100000));
        vecs.push_back(mk(1, 1, 1, 0, 3'd0, 2, 8'd1, 0, 6'b001000));
        vecs.push_back(mk(1, 0, 1, 1, 3'd2, 3, 8'd16, 0, 6'b110000));
        vecs.push_back(mk(0, 0, 0, 0, 3'd0, 3, 8'd16, 0, 6'b100000));
        vecs.push_back(mk(1, 1, 1, 0, 3'd0, 4, 8'd1, 0, 6'b001100));
        vecs.push_back(mk(1, 0, 1, 1, 3'd3, 5, 8'd0, 1, 6'b001000));
        vecs.push_back(mk(1, 0, 1, 0, 3'd2, 6, 8'd16, 1, 6'b100011));
        vecs.push_back(mk(1, 1, 1, 1, 3'd1, 0, 8'd0, 0, 6'b001000));
        vecs.push_back(mk(1, 0, 1, 1, 3'd2, 11, 8'd0, 1, 6'b100011));
        vecs.push_back(mk(1, 1, 1, 0, 3'd0, 7, 8'd200, 1, 6'b100001));
        vecs.push_back(mk(1, 1, 1, 0, 3'd0, 8, 8'd100, 1, 6'b001001));
        vecs.push_back(mk(1, 0, 1, 1, 3'd2, 9, 8'd44, 0, 6'b000001));
        for (int k = 0; k < 8; k++)
            vecs.push_back(mk(1, 0, 1, 1, 3'(k), 10, alu_exp[k], 0, (k == 7) ? 6'b100001 : 6'b000001));
        vecs.push_back(mk(1, 1, 1, 1, 3'd0, 12, 8'd80, 1, 6'b110000));
        vecs.push_back(mk(0, 0, 0, 0, 3'd0, 12, 8'd80, 1, 6'b111111));
        vecs.push_back(mk(1, 0, 0, 0, 3'd0, 12, 8'd80, 1, 6'b100000));

        #12;
        chk("reset opcode", 32'(Opcode), 32'(6'b100000));
        chk("reset zero", 32'(zero), 32'd0);
        chk("reset R1", 32'(dut.u_rf.regs[1]), 32'd0);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("vec%0d", i));

        step(mk(1, 1, 1, 0, 3'd0, 1, 8'd15, 1, 6'b100000), "rerun0");
        step(mk(1, 1, 1, 0, 3'd0, 2, 8'd1, 1, 6'b001000), "rerun1");
        step(mk(1, 0, 1, 0, 3'd2, 3, 8'd16, 1, 6'b110000), "rerun2");

        #2;
        reset = 1'b0;
        #1;
        chk("midreset opcode", 32'(Opcode), 32'(6'b100000));
        chk("midreset zero", 32'(zero), 32'd0);
        for (int r = 1; r < 16; r++)
            chk($sformatf("midreset R%0d", r), 32'(dut.u_rf.regs[r]), 32'd0);
        #3;
        reset = 1'b1;
        step(mk(1, 1, 1, 0, 3'd0, 1, 8'd15, 0, 6'b100000), "resume0");
        step(mk(1, 1, 1, 0, 3'd0, 2, 8'd1, 0, 6'b001000), "resume1");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
